// File: rtl/capture_send_sequencer.sv
// rtl/capture_send_sequencer.sv - capture freeze and UART frame send sequencer
// Waits for a frame boundary, freezes the buffer, handshakes the sender, then resumes or holds.
module capture_send_sequencer #(
  parameter int SETTLE_CYCLES = 16,
  parameter int VSYNC_TIMEOUT = 8_333_334,
  parameter int AUTO_RESUME   = 1,
  parameter int CNT_WIDTH     = $clog2(VSYNC_TIMEOUT + 1)
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       vsync_s,
  input  logic       cap_req,
  input  logic       resume_req,
  input  logic       abort,
  input  logic       send_busy,
  output logic       capture_enable,
  output logic       frozen,
  output logic       send_start,
  output logic       busy,
  output logic       timeout_err,
  output logic [7:0] frame_cnt
);

  localparam logic [2:0] S_LIVE   = 3'd0;
  localparam logic [2:0] S_ARM    = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_REQ    = 3'd3;
  localparam logic [2:0] S_SEND   = 3'd4;
  localparam logic [2:0] S_HOLD   = 3'd5;

  localparam logic [CNT_WIDTH-1:0] C_TIMEOUT_LAST = CNT_WIDTH'(VSYNC_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] C_SETTLE_LAST  = CNT_WIDTH'(SETTLE_CYCLES - 1);

  logic [2:0]           r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_vsync_d;
  logic                 r_timeout_err;
  logic [7:0]           r_frame_cnt;

  logic [2:0] w_state_nxt;
  logic       w_cnt_clr;
  logic       w_cnt_inc;
  logic       w_err_set;
  logic       w_err_clr;
  logic       w_frame_inc;
  logic       w_vsync_rise;

  assign w_vsync_rise = vsync_s & ~r_vsync_d;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_err_set   = 1'b0;
    w_err_clr   = 1'b0;
    w_frame_inc = 1'b0;
    case (r_state)
      S_LIVE: begin
        if (cap_req) begin
          w_state_nxt = S_ARM;
          w_cnt_clr   = 1'b1;
          w_err_clr   = 1'b1;
        end
      end
      S_ARM: begin
        // A vsync edge on the last counted cycle still wins over the timeout.
        if (abort) begin
          w_state_nxt = S_LIVE;
        end else if (w_vsync_rise) begin
          w_state_nxt = S_SETTLE;
          w_cnt_clr   = 1'b1;
        end else if (r_cnt == C_TIMEOUT_LAST) begin
          w_state_nxt = S_LIVE;
          w_err_set   = 1'b1;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          w_state_nxt = S_LIVE;
        end else if (r_cnt == C_SETTLE_LAST) begin
          w_state_nxt = S_REQ;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_REQ: begin
        if (abort) begin
          w_state_nxt = S_LIVE;
        end else if (send_busy) begin
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        // Abort is not honoured here: the sender still reads the frozen buffer.
        if (!send_busy) begin
          w_frame_inc = 1'b1;
          w_state_nxt = (AUTO_RESUME != 0) ? S_LIVE : S_HOLD;
        end
      end
      S_HOLD: begin
        if (abort) begin
          w_state_nxt = S_LIVE;
        end else if (cap_req) begin
          w_state_nxt = S_ARM;
          w_cnt_clr   = 1'b1;
          w_err_clr   = 1'b1;
        end else if (resume_req) begin
          w_state_nxt = S_LIVE;
        end
      end
      default: w_state_nxt = S_LIVE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_LIVE;
      r_cnt         <= '0;
      r_vsync_d     <= 1'b0;
      r_timeout_err <= 1'b0;
      r_frame_cnt   <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_vsync_d <= vsync_s;
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
      if (w_err_clr) begin
        r_timeout_err <= 1'b0;
      end else if (w_err_set) begin
        r_timeout_err <= 1'b1;
      end
      if (w_frame_inc) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  assign capture_enable = (r_state == S_LIVE) || (r_state == S_ARM);
  assign frozen         = ~capture_enable;
  assign send_start     = (r_state == S_REQ);
  assign busy           = (r_state == S_ARM) || (r_state == S_SETTLE) ||
                          (r_state == S_REQ) || (r_state == S_SEND);
  assign timeout_err    = r_timeout_err;
  assign frame_cnt      = r_frame_cnt;

endmodule

// File: tb/tb_capture_send_sequencer.sv
// tb/tb_capture_send_sequencer.sv - directed self-checking bench for capture_send_sequencer
module tb_capture_send_sequencer;

  localparam int SET = 4;
  localparam int TMO = 100;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic vsync_s = 1'b0;
  logic cap_req = 1'b0;
  logic resume_req = 1'b0;
  logic abort = 1'b0;
  logic send_busy = 1'b0;

  logic       ce0, fr0, ss0, bz0, te0;
  logic [7:0] fc0;
  logic       ce1, fr1, ss1, bz1, te1;
  logic [7:0] fc1;

  int n_total = 0;
  int n_bad   = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  capture_send_sequencer #(.SETTLE_CYCLES(SET), .VSYNC_TIMEOUT(TMO), .AUTO_RESUME(1)) dut0 (
    .clk(clk), .reset_n(reset_n), .vsync_s(vsync_s), .cap_req(cap_req),
    .resume_req(resume_req), .abort(abort), .send_busy(send_busy),
    .capture_enable(ce0), .frozen(fr0), .send_start(ss0), .busy(bz0),
    .timeout_err(te0), .frame_cnt(fc0)
  );

  capture_send_sequencer #(.SETTLE_CYCLES(SET), .VSYNC_TIMEOUT(TMO), .AUTO_RESUME(0)) dut1 (
    .clk(clk), .reset_n(reset_n), .vsync_s(vsync_s), .cap_req(cap_req),
    .resume_req(resume_req), .abort(abort), .send_busy(send_busy),
    .capture_enable(ce1), .frozen(fr1), .send_start(ss1), .busy(bz1),
    .timeout_err(te1), .frame_cnt(fc1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_cap();
    cap_req = 1'b1;
    tick();
    cap_req = 1'b0;
  endtask

  task automatic to_settle();
    vsync_s = 1'b0;
    pulse_cap();
    tick();
    vsync_s = 1'b1;
    tick();
    vsync_s = 1'b0;
  endtask

  task automatic to_req();
    to_settle();
    repeat (SET) tick();
  endtask

  task automatic to_send();
    to_req();
    send_busy = 1'b1;
    tick();
  endtask

  task automatic end_send();
    send_busy = 1'b0;
    tick();
    exp_cnt = (exp_cnt + 1) % 256;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    exp_cnt = 0;
  endtask

  task automatic live_outputs(input string tag);
    check({tag, "_ce"}, ce0, 1);
    check({tag, "_ss"}, ss0, 0);
    check({tag, "_busy"}, bz0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #3;
    check("rst_ce", ce0, 1);
    check("rst_frozen", fr0, 0);
    check("rst_ss", ss0, 0);
    check("rst_busy", bz0, 0);
    check("rst_te", te0, 0);
    check("rst_fc", fc0, 0);
    tick();
    reset_n = 1'b1;
    tick();

    // Normal flow
    pulse_cap();
    check("nf_busy_after_cap", bz0, 1);
    check("nf_ce_in_arm", ce0, 1);
    repeat (19) tick();
    vsync_s = 1'b1;
    tick();
    check("nf_ce_after_edge", ce0, 0);
    check("nf_frozen_after_edge", fr0, 1);
    repeat (SET - 1) tick();
    check("nf_ss_early", ss0, 0);
    tick();
    check("nf_ss_rise", ss0, 1);
    tick();
    check("nf_ss_held", ss0, 1);
    send_busy = 1'b1;
    tick();
    check("nf_ss_after_ack", ss0, 0);
    check("nf_busy_send", bz0, 1);
    repeat (49) tick();
    check("nf_fc_during_send", fc0, 0);
    check("nf_frozen_during_send", fr0, 1);
    end_send();
    vsync_s = 1'b0;
    check("nf_fc_done", fc0, 1);
    check("nf_ce_done", ce0, 1);
    check("nf_busy_done", bz0, 0);

    // Vsync timeout
    pulse_cap();
    repeat (TMO - 1) tick();
    check("to_busy_before", bz0, 1);
    check("to_te_before", te0, 0);
    tick();
    check("to_busy_after", bz0, 0);
    check("to_te_after", te0, 1);
    pulse_cap();
    check("to_te_cleared", te0, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // Vsync edge coincident with cap_req is not counted
    vsync_s = 1'b1;
    pulse_cap();
    repeat (3) tick();
    check("vc_still_armed", bz0, 1);
    check("vc_ce_live", ce0, 1);
    vsync_s = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    live_outputs("ab_arm");

    // Abort in SETTLE and REQ
    to_settle();
    check("ab_settle_frozen", fr0, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    live_outputs("ab_settle");
    to_req();
    check("ab_req_ss", ss0, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    live_outputs("ab_req");
    check("ab_te_kept", te0, 0);

    // Abort and cap_req ignored in SEND
    to_send();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_send_busy", bz0, 1);
    check("ab_send_frozen", fr0, 1);
    pulse_cap();
    check("cap_send_busy", bz0, 1);
    end_send();
    check("ab_send_fc", fc0, 8'(exp_cnt));
    live_outputs("cap_send_done");
    tick();
    check("cap_send_not_armed", bz0, 0);

    // Hold mode
    do_reset();
    to_send();
    end_send();
    check("hold_frozen", fr1, 1);
    check("hold_busy", bz1, 0);
    check("hold_fc", fc1, 1);
    cap_req = 1'b1;
    resume_req = 1'b1;
    tick();
    cap_req = 1'b0;
    resume_req = 1'b0;
    check("hold_recap_busy", bz1, 1);
    check("hold_recap_ce", ce1, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("hold_abort_busy", bz1, 0);
    to_send();
    end_send();
    resume_req = 1'b1;
    tick();
    resume_req = 1'b0;
    check("hold_resume_ce", ce1, 1);
    check("hold_resume_fc", fc1, 2);

    // Reset mid-SEND
    to_send();
    check("rs_pre_fc", fc0, 8'(exp_cnt));
    #2;
    reset_n = 1'b0;
    #1;
    check("rs_ce", ce0, 1);
    check("rs_frozen", fr0, 0);
    check("rs_busy", bz0, 0);
    check("rs_fc", fc0, 0);
    check("rs_te", te0, 0);
    send_busy = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    exp_cnt = 0;

    // Counter wrap
    for (int i = 0; i < 256; i++) begin
      to_send();
      end_send();
      if (i == 254) check("wrap_255", fc0, 8'd255);
    end
    check("wrap_0", fc0, 8'd0);
    check("wrap_model", fc0, 8'(exp_cnt));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/capture_send_sequencer.md
# capture_send_sequencer

Sequences the capture-and-send flow of the camera path in the `clk` domain. On a capture request it waits for the next frame boundary and then freezes the capture frame buffer by dropping `capture_enable`. It then starts the UART frame sender with a req/ack handshake, waits for the sender to finish, and either resumes live capture or holds the frozen frame. It sits between the command sources (debounced button, UART RX command decoder) and the capture-buffer write gate plus the UART TX frame sender.

## Interface
- `SETTLE_CYCLES`, 16, cycles spent frozen before requesting the send; lets the last pclk-domain writes land. Must be ≥1.
- `VSYNC_TIMEOUT`, 8_333_334, max `clk` cycles to wait for a vsync edge while armed (about 2 frames at 125 MHz).
- `AUTO_RESUME`, 1, 1: return to live capture after the send; 0: hold the frozen frame until `resume_req`.
- `CNT_WIDTH`, `$clog2(VSYNC_TIMEOUT+1)`, width of the shared wait counter.

Ports:
- `clk` in 1: system clock (125 MHz).
- `reset_n` in 1: asynchronous, active-low reset.
- `vsync_s` in 1: camera vsync, already synchronized to `clk`.
- `cap_req` in 1: single-cycle capture request.
- `resume_req` in 1: single-cycle request to leave HOLD.
- `abort` in 1: single-cycle cancel.
- `send_busy` in 1: UART TX frame sender busy (its `sending` output).
- `capture_enable` out 1: write gate for the capture frame buffer; 1 = follow the camera.
- `frozen` out 1: equal to `~capture_enable`.
- `send_start` out 1: send request, held until acknowledged.
- `busy` out 1: 1 in ARM, SETTLE, REQ and SEND.
- `timeout_err` out 1: sticky vsync-timeout flag.
- `frame_cnt` out 8: completed sends, wraps from 255 to 0.

## Operation
States are LIVE, ARM, SETTLE, REQ, SEND and HOLD. All outputs are registered and decoded from the state register.

- **LIVE**: `capture_enable`=1.
  - `cap_req` → ARM. Clears the counter and `timeout_err`.
  - `abort` has no effect.
- **ARM**: `capture_enable`=1. The counter increments every cycle.
  - Rising edge of `vsync_s` (`vsync_s & ~vsync_d`, with `vsync_d` registered and reset to 0) → SETTLE, counter cleared.
  - Counter = `VSYNC_TIMEOUT`-1 with no edge → LIVE and `timeout_err`=1.
  - If an edge and the timeout occur in the same cycle, the edge wins.
- **SETTLE**: frozen. After `SETTLE_CYCLES` cycles in this state → REQ.
- **REQ**: frozen, `send_start`=1.
  - `send_busy`=1 → SEND.
  - REQ waits indefinitely for the ack.
- **SEND**: frozen, `send_start`=0.
  - `send_busy`=0 → `frame_cnt`+1, then go to LIVE if `AUTO_RESUME`=1, else HOLD.
  - `abort` is ignored here: the sender is still reading the frozen buffer.
- **HOLD**: frozen, `busy`=0.
  - `resume_req` → LIVE.
  - `cap_req` → ARM (re-capture), clearing `timeout_err`.
- **`abort`**: in ARM, SETTLE, REQ or HOLD, goes to LIVE on the next cycle. `send_start` drops and `timeout_err` is unchanged.

Priorities:
- In LIVE, `cap_req` wins over `abort`.
- In HOLD, `abort` beats `cap_req`, which beats `resume_req`.
- `cap_req` is ignored in ARM, SETTLE, REQ and SEND.
- A vsync edge that occurs in the same cycle as `cap_req` (while still in LIVE) is not counted; edge detection applies only while in ARM.

Other rules:
- If `send_busy` is already 1 on entry to REQ, the ack is taken in that first cycle. `send_start` is high for exactly one cycle.
- Reset in any state forces LIVE immediately. Asynchronous reset values:
  - `capture_enable`=1, `frozen`=0
  - `send_start`=0, `busy`=0
  - `timeout_err`=0, `frame_cnt`=0
  - counter=0, `vsync_d`=0

## Timing
- Edge detected at cycle N while in ARM → state=SETTLE and `capture_enable`=0 from N+1.
- `send_start` rises at N+1+`SETTLE_CYCLES`.
- Ack sampled at cycle M → `send_start`=0 from M+1.
- `send_busy` low sampled at cycle K → `frame_cnt` updated and `capture_enable`=1 (AUTO_RESUME) from K+1.
- `cap_req` at cycle C in LIVE → `busy`=1 from C+1.
- Timeout: `timeout_err` and LIVE take effect `VSYNC_TIMEOUT` cycles after entering ARM.
- `abort` at cycle A → LIVE outputs from A+1.

## Test plan
Bench parameters: `SETTLE_CYCLES`=4, `VSYNC_TIMEOUT`=100, `AUTO_RESUME`=1 unless noted.
- **Normal flow**: `cap_req` pulse, vsync rise 20 cycles later, `send_busy` high 2 cycles after `send_start` and for 50 cycles → `capture_enable` 0 one cycle after the edge, `send_start` 4 cycles later, then `frame_cnt`=1 and `capture_enable`=1 one cycle after `send_busy` falls.
- **Vsync timeout**: `cap_req` with vsync held low → after 100 cycles, LIVE with `timeout_err`=1; the next `cap_req` clears it.
- **Hold mode** (`AUTO_RESUME`=0): complete one send → HOLD with `frozen`=1 and `busy`=0. `cap_req` and `resume_req` in the same cycle → ARM.
- **Abort handling**: `abort` in ARM, SETTLE and REQ → LIVE next cycle with `send_start` 0. `abort` in SEND → ignored, and the send completes with `frame_cnt` incremented.
- **Mid-operation reset and ignored requests**: `reset_n` low mid-SEND → all outputs at reset values immediately. `cap_req` during SEND → ignored.
- **Counter wrap**: 256 completed sends → `frame_cnt` wraps to 0.
